// File: rtl/tamper_response_ctrl.sv
// tamper_response_ctrl: captures TAMPER macro events and sequences the lockdown/zeroize/reset response with a software ack.
module tamper_response_ctrl #(
  parameter int HOLD_CYCLES   = 16,
  parameter int ESC_THRESHOLD = 3,
  parameter int CNT_W         = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TAMPER_CHANGE_STROBE,
  input  logic [3:0]       DETECT_CATEGORY,
  input  logic             DETECT_ATTEMPT,
  input  logic             DETECT_FAIL,
  input  logic             DIGEST_ERROR,
  input  logic             SC_ROM_DIGEST_ERROR,
  input  logic             MESH_SHORT_ERROR,
  input  logic             JTAG_ACTIVE,
  input  logic             LOCKDOWN_EN,
  input  logic             ZEROIZE_EN,
  input  logic             ACK,
  output logic             IRQ,
  output logic [3:0]       EVENT_CAT,
  output logic [5:0]       EVENT_FLAGS,
  output logic [CNT_W-1:0] ATTEMPT_COUNT,
  output logic             LOCKDOWN_ALL_N,
  output logic             DISABLE_ALL_IOS_N,
  output logic             ZEROIZE_N,
  output logic             TAMPER_RESET_N,
  output logic [2:0]       STATE
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    LOCK     = 3'd2,
    ZEROIZE  = 3'd3,
    WAIT_ACK = 3'd4,
    CLEAR    = 3'd5
  } state_t;
  state_t state, state_n;
  logic [2:0] sync;
  logic edge_p, pending, overrun, zeroized, held;
  logic [4:0] ev_flags;
  logic [7:0] hold_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic hold_done, escalate, lock_req, lock_low;
  always_comb begin
    cnt_inc = (DETECT_ATTEMPT && !(&ATTEMPT_COUNT)) ? ATTEMPT_COUNT + CNT_W'(1) : ATTEMPT_COUNT;
    hold_done = hold_cnt == 8'(HOLD_CYCLES - 1);
    escalate = ZEROIZE_EN && (DIGEST_ERROR || SC_ROM_DIGEST_ERROR || MESH_SHORT_ERROR ||
                              cnt_inc >= CNT_W'(ESC_THRESHOLD));
    lock_req = LOCKDOWN_EN && (DETECT_FAIL || DETECT_CATEGORY != 4'd0);
    state_n = state;
    case (state)
      IDLE:          state_n = (edge_p || pending) ? CAPTURE : IDLE;
      CAPTURE:       state_n = escalate ? ZEROIZE : lock_req ? LOCK : WAIT_ACK;
      LOCK, ZEROIZE: state_n = hold_done ? WAIT_ACK : state;
      WAIT_ACK:      state_n = ACK ? CLEAR : WAIT_ACK;
      default:       state_n = IDLE;
    endcase
  end
  // The registered edge pulse makes the FSM leave IDLE exactly three edges after the strobe rises.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      sync          <= 3'b000;
      edge_p        <= 1'b0;
      pending       <= 1'b0;
      overrun       <= 1'b0;
      zeroized      <= 1'b0;
      held          <= 1'b0;
      hold_cnt      <= 8'd0;
      ev_flags      <= 5'd0;
      EVENT_CAT     <= 4'd0;
      ATTEMPT_COUNT <= '0;
    end else begin
      state    <= state_n;
      sync     <= {sync[1:0], TAMPER_CHANGE_STROBE};
      edge_p   <= sync[1] & ~sync[2];
      hold_cnt <= (state == LOCK || state == ZEROIZE) ? hold_cnt + 8'd1 : 8'd0;
      pending  <= (state == IDLE) ? pending & edge_p : pending | edge_p;
      overrun  <= (overrun && state != CAPTURE) || (state != IDLE && edge_p && pending);
      zeroized <= zeroized || state == ZEROIZE;
      held     <= (state == CLEAR) ? 1'b0 : held || state == LOCK || state == ZEROIZE;
      if (state == CAPTURE) begin
        EVENT_CAT     <= DETECT_CATEGORY;
        ev_flags      <= {JTAG_ACTIVE, MESH_SHORT_ERROR, SC_ROM_DIGEST_ERROR, DIGEST_ERROR, DETECT_FAIL};
        ATTEMPT_COUNT <= cnt_inc;
      end
    end
  end
  // Once zeroized, the lockdown pins stay asserted until RESET.
  assign lock_low          = state == LOCK || state == ZEROIZE || (held && state == WAIT_ACK) || zeroized;
  assign LOCKDOWN_ALL_N    = ~lock_low;
  assign DISABLE_ALL_IOS_N = ~lock_low;
  assign ZEROIZE_N         = state != ZEROIZE;
  assign TAMPER_RESET_N    = state != CLEAR;
  assign IRQ               = state == WAIT_ACK;
  assign EVENT_FLAGS       = {overrun, ev_flags};
  assign STATE             = state;
endmodule

// File: tb/tb_tamper_response_ctrl.sv
// tb_tamper_response_ctrl: directed and random tamper events checked by a queue-based scoreboard.
module tb_tamper_response_ctrl;
  localparam int HOLD = 16;
  localparam int ESC  = 3;
  logic clk = 0, rst = 1, strobe = 0, att = 0, fail = 0, dig = 0, rom = 0, mesh = 0, jtag = 0;
  logic len = 0, zen = 0, ack = 0;
  logic [3:0] cat = 0;
  logic irq, lock_n, dis_n, zero_n, trst_n;
  logic [3:0] ev_cat;
  logic [5:0] ev_flags;
  logic [7:0] att_cnt;
  logic [2:0] state;
  typedef struct {int cat; int flags; int cnt; int zlen; int llen; int lock_n;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, m_cnt = 0;
  bit m_sticky = 0;
  tamper_response_ctrl #(.HOLD_CYCLES(HOLD), .ESC_THRESHOLD(ESC), .CNT_W(8)) dut (
    .CLK(clk), .RESET(rst), .TAMPER_CHANGE_STROBE(strobe), .DETECT_CATEGORY(cat),
    .DETECT_ATTEMPT(att), .DETECT_FAIL(fail), .DIGEST_ERROR(dig), .SC_ROM_DIGEST_ERROR(rom),
    .MESH_SHORT_ERROR(mesh), .JTAG_ACTIVE(jtag), .LOCKDOWN_EN(len), .ZEROIZE_EN(zen), .ACK(ack),
    .IRQ(irq), .EVENT_CAT(ev_cat), .EVENT_FLAGS(ev_flags), .ATTEMPT_COUNT(att_cnt),
    .LOCKDOWN_ALL_N(lock_n), .DISABLE_ALL_IOS_N(dis_n), .ZEROIZE_N(zero_n),
    .TAMPER_RESET_N(trst_n), .STATE(state)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: what a captured event must look like, derived from the current inputs.
  task automatic push_exp(bit ovr);
    exp_t e;
    bit z, l;
    if (att) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    z = zen && (dig || rom || mesh || m_cnt >= ESC);
    l = !z && len && (fail || cat != 0);
    e.cat = cat;
    e.flags = {ovr, jtag, mesh, rom, dig, fail};
    e.cnt = m_cnt;
    e.zlen = z ? HOLD : 0;
    e.llen = m_sticky ? -1 : (z || l) ? HOLD : 0;
    e.lock_n = !(z || l || m_sticky);
    m_sticky = m_sticky || z;
    q.push_back(e);
  endtask
  task automatic set_in(int c, bit a, bit f, bit d, bit r, bit m, bit j, bit le, bit ze);
    cat = 4'(c); att = a; fail = f; dig = d; rom = r; mesh = m; jtag = j; len = le; zen = ze;
  endtask
  task automatic check_reset();
    chk("rst_irq", irq, 0); chk("rst_cat", ev_cat, 0); chk("rst_flags", ev_flags, 0);
    chk("rst_count", att_cnt, 0); chk("rst_state", state, 0); chk("rst_lock_n", lock_n, 1);
    chk("rst_dis_n", dis_n, 1); chk("rst_zero_n", zero_n, 1); chk("rst_trst_n", trst_n, 1);
  endtask
  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_cnt = 0; m_sticky = 0; q.delete();
  endtask
  task automatic strobe_pulse(int hi, int lo);
    strobe = 1;
    repeat (hi) @(negedge clk);
    strobe = 0;
    repeat (lo) @(negedge clk);
  endtask
  task automatic wait_irq();
    int n = 0;
    while (!irq && n < 300) begin @(negedge clk); n++; end
    chk("irq_wait", irq, 1);
  endtask
  task automatic ack_chk();
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("clear_trst_low", trst_n, 0); chk("clear_irq", irq, 0);
    chk("clear_lock_n", lock_n, !m_sticky); chk("clear_dis_n", dis_n, !m_sticky);
    @(negedge clk);
    chk("trst_one_cycle", trst_n, 1);
  endtask
  // Monitor: pops one expectation per IRQ rise and measures how long the response pins were held.
  initial begin
    int zlen = 0, llen = 0;
    bit prev_irq = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !trst_n) begin zlen = 0; llen = 0; end
      else if (!irq) begin
        if (!zero_n) zlen++;
        if (!lock_n) llen++;
      end
      if (irq && !prev_irq) begin
        if (q.size() == 0) chk("unexpected_irq", 1, 0);
        else begin
          e = q.pop_front();
          chk("event_cat", ev_cat, e.cat); chk("event_flags", ev_flags, e.flags);
          chk("attempt_count", att_cnt, e.cnt); chk("zeroize_len", zlen, e.zlen);
          chk("irq_lock_n", lock_n, e.lock_n); chk("irq_dis_n", dis_n, e.lock_n);
          chk("irq_zero_n", zero_n, 1);
          if (e.llen >= 0) chk("lock_len", llen, e.llen);
        end
      end
      prev_irq = irq;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    @(negedge clk);
    check_reset();
    rst = 0;
    // Lock event with ignored ACKs during the hold
    set_in(2, 0, 1, 0, 0, 0, 0, 1, 0);
    push_exp(0);
    strobe = 1;
    repeat (4) @(negedge clk);
    chk("capture_after_edge3", state, 1);
    @(negedge clk);
    strobe = 0;
    chk("lock_first_cycle", lock_n, 0);
    ack = 1; @(negedge clk); ack = 0;
    repeat (3) @(negedge clk);
    ack = 1; @(negedge clk); ack = 0;
    wait_irq();
    ack_chk();
    chk("idle_after_clear", state, 0);
    // Attempts escalating to zeroize
    do_reset();
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) begin
      push_exp(0);
      strobe_pulse(6, 3);
      wait_irq();
      ack_chk();
    end
    repeat (5) @(negedge clk);
    chk("sticky_lock_n", lock_n, 0);
    // Digest error with no response, then strobe coincident with ACK
    do_reset();
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0);
    push_exp(0);
    strobe_pulse(6, 3);
    wait_irq();
    push_exp(0);
    strobe = 1;
    repeat (3) @(negedge clk);
    ack_chk();
    strobe = 0;
    wait_irq();
    ack_chk();
    // Two strobes during the lock hold -> overrun, then pending re-capture
    do_reset();
    set_in(2, 0, 1, 0, 0, 0, 1, 1, 0);
    push_exp(1);
    push_exp(0);
    strobe = 1;
    n = 0;
    while (lock_n && n < 50) begin @(negedge clk); n++; end
    chk("lock_entered", lock_n, 0);
    strobe = 0;
    repeat (2) @(negedge clk);
    strobe_pulse(3, 3);
    strobe_pulse(3, 3);
    wait_irq();
    ack_chk();
    wait_irq();
    ack_chk();
    // Reset in the middle of a zeroize pulse
    do_reset();
    set_in(0, 1, 0, 1, 0, 0, 0, 1, 1);
    push_exp(0);
    strobe = 1;
    n = 0;
    while (zero_n && n < 50) begin @(negedge clk); n++; end
    strobe = 0;
    repeat (7) @(negedge clk);
    chk("zeroize_before_reset", zero_n, 0);
    #2 rst = 1;
    #1 check_reset();
    @(negedge clk);
    rst = 0; m_cnt = 0; m_sticky = 0; q.delete();
    // Saturation of the attempt counter
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (256) begin
      push_exp(0);
      strobe_pulse(4, 3);
      wait_irq();
      ack_chk();
    end
    chk("count_saturated", att_cnt, 255);
    // Randomized events
    do_reset();
    repeat (40) begin
      set_in(($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 15), $urandom_range(0, 1) != 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
             $urandom_range(0, 1) != 0);
      push_exp(0);
      strobe_pulse(6, 3);
      wait_irq();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      ack_chk();
      repeat (3) @(negedge clk);
    end
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tamper_response_ctrl.md
Name: tamper_response_ctrl

Overview:
- Fabric-side controller for the SmartFusion2 TAMPER macro.
- Captures tamper events flagged by TAMPER_CHANGE_STROBE and latches the category and error flags.
- Keeps a saturating attempt count and sequences the response pins of the macro (LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N, ZEROIZE_N, RESET_N) through an FSM with a software acknowledge handshake.
- Sits between the TAMPER wrapper and the MSS/APB status logic.

Parameters:
- HOLD_CYCLES, 16: minimum cycles a lockdown/zeroize response is held before the IRQ is raised (valid range 1..255).
- ESC_THRESHOLD, 3: attempt count at or above which a captured event escalates to zeroize.
- CNT_W, 8: attempt counter width.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- TAMPER_CHANGE_STROBE  in  1  from macro; asynchronous to CLK.
- DETECT_CATEGORY  in  4  from macro.
- DETECT_ATTEMPT  in  1  from macro.
- DETECT_FAIL  in  1  from macro.
- DIGEST_ERROR  in  1  from macro.
- SC_ROM_DIGEST_ERROR  in  1  from macro.
- MESH_SHORT_ERROR  in  1  from macro.
- JTAG_ACTIVE  in  1  from macro.
- LOCKDOWN_EN  in  1  policy: permit lockdown response.
- ZEROIZE_EN  in  1  policy: permit zeroize response.
- ACK  in  1  software acknowledge, one-cycle pulse.
- IRQ  out  1  event awaiting acknowledge.
- EVENT_CAT  out  4  latched category.
- EVENT_FLAGS  out  6  {OVERRUN, JTAG_ACTIVE, MESH_SHORT_ERROR, SC_ROM_DIGEST_ERROR, DIGEST_ERROR, DETECT_FAIL}.
- ATTEMPT_COUNT  out  CNT_W  saturating count of DETECT_ATTEMPT events.
- LOCKDOWN_ALL_N  out  1  to macro, active-low.
- DISABLE_ALL_IOS_N  out  1  to macro, active-low.
- ZEROIZE_N  out  1  to macro, active-low.
- TAMPER_RESET_N  out  1  to macro RESET_N, active-low.
- STATE  out  3  FSM state for debug.

Behaviour:
- Reset values:
  - IRQ=0, EVENT_CAT=0, EVENT_FLAGS=0, ATTEMPT_COUNT=0, STATE=IDLE(0).
  - LOCKDOWN_ALL_N=1, DISABLE_ALL_IOS_N=1, ZEROIZE_N=1, TAMPER_RESET_N=1.
  - Pending and sticky bits cleared.
- Strobe handling:
  - TAMPER_CHANGE_STROBE passes through a 2-flop synchronizer, then a rising-edge detector.
  - An input rising before clock edge 0 gives the edge pulse after edge 2; the FSM is in CAPTURE after edge 3.
  - Other macro inputs are sampled only in CAPTURE; they are quasi-static while the strobe is high.
- State encoding: IDLE=0, CAPTURE=1, LOCK=2, ZEROIZE=3, WAIT_ACK=4, CLEAR=5.
- IDLE:
  - Edge or pending bit set -> CAPTURE; the pending bit is cleared.
- CAPTURE (1 cycle):
  - Latch EVENT_CAT and EVENT_FLAGS[4:0].
  - If DETECT_ATTEMPT, ATTEMPT_COUNT increments, saturating at all-ones.
  - Escalation uses the post-increment count.
  - Next state:
    - ZEROIZE if ZEROIZE_EN & (DIGEST_ERROR | SC_ROM_DIGEST_ERROR | MESH_SHORT_ERROR | count>=ESC_THRESHOLD).
    - Else LOCK if LOCKDOWN_EN & (DETECT_FAIL | DETECT_CATEGORY!=0).
    - Else WAIT_ACK.
- LOCK:
  - LOCKDOWN_ALL_N=0 and DISABLE_ALL_IOS_N=0 from the first cycle.
  - Hold counter runs HOLD_CYCLES cycles, then -> WAIT_ACK. Both outputs stay low until CLEAR.
- ZEROIZE:
  - ZEROIZE_N=0, LOCKDOWN_ALL_N=0, DISABLE_ALL_IOS_N=0 for HOLD_CYCLES cycles.
  - ZEROIZE_N returns to 1 on exit -> WAIT_ACK.
  - Sets a sticky zeroized bit.
- WAIT_ACK:
  - IRQ=1.
  - ACK -> CLEAR (IRQ=0 in CLEAR).
- CLEAR (1 cycle):
  - TAMPER_RESET_N=0.
  - LOCKDOWN_ALL_N and DISABLE_ALL_IOS_N return to 1 unless the sticky zeroized bit is set. Once zeroized, they stay low until RESET.
  - -> IDLE.
- ACK outside WAIT_ACK is ignored.
- Strobe edge while not in IDLE:
  - If pending=0, set pending; it is serviced on return to IDLE.
  - If pending=1, set EVENT_FLAGS[5] OVERRUN (sticky until the next CAPTURE of a fresh event, then cleared).
  - An edge coincident with ACK in WAIT_ACK sets pending and is not lost.
- ATTEMPT_COUNT is cleared only by RESET, never by ACK.
- RESET mid-sequence:
  - All outputs return to reset values immediately (asynchronously).
  - ZEROIZE_N deasserts even mid-pulse; the zeroized sticky bit clears.

Test Plan:
- Strobe with CATEGORY=4'h2, DETECT_FAIL=1, LOCKDOWN_EN=1 -> CAPTURE after edge 3; LOCKDOWN_ALL_N/DISABLE_ALL_IOS_N low for 16 cycles; IRQ=1, EVENT_CAT=2; ACK -> TAMPER_RESET_N low 1 cycle, lockdown released, STATE=0.
- Three strobes with DETECT_ATTEMPT=1, each acked, ZEROIZE_EN=1 -> ATTEMPT_COUNT=1,2,3; third goes to ZEROIZE, ZEROIZE_N low 16 cycles; after ACK, LOCKDOWN_ALL_N stays 0 until RESET.
- DIGEST_ERROR=1 with ZEROIZE_EN=0, LOCKDOWN_EN=0 -> CAPTURE -> WAIT_ACK directly; EVENT_FLAGS=6'b000010; no response pins toggle.
- Two strobes during LOCK hold, then ACK -> OVERRUN=1 in EVENT_FLAGS; the pending event is re-captured straight from IDLE, clearing OVERRUN; IRQ reasserts.
- ACK pulses during LOCK hold -> ignored, IRQ still rises at hold end; strobe coincident with ACK in WAIT_ACK -> second CAPTURE follows CLEAR.
- RESET asserted at hold cycle 8 of ZEROIZE -> ZEROIZE_N=1 and all outputs at reset values within the same cycle; ATTEMPT_COUNT=0.
- Drive 256 attempt events with CNT_W=8 -> ATTEMPT_COUNT saturates at 255.
